// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bus between a bit source and the deserializer.
// The master drives the serial side and the downstream ready.
// The slave (the deserializer) returns the assembled word and its status.
interface sipo_deserializer_if #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) ();

    logic          shift_en;
    logic          serial_in;
    logic          frame_clr;
    logic          out_ready;
    logic [N-1:0]  parallel_out;
    logic          out_valid;
    logic [CW-1:0] bit_count;
    logic          overrun;

    modport master (
        output shift_en,
        output serial_in,
        output frame_clr,
        output out_ready,
        input  parallel_out,
        input  out_valid,
        input  bit_count,
        input  overrun
    );

    modport slave (
        input  shift_en,
        input  serial_in,
        input  frame_clr,
        input  out_ready,
        output parallel_out,
        output out_valid,
        output bit_count,
        output overrun
    );

endinterface

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer with a one-word output holding
// register. The output FSM is EMPTY/FULL. A word that completes while the
// holding register is full and not being drained is dropped, and the sticky
// overrun flag is raised.
module sipo_deserializer #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    sipo_deserializer_if.slave bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [N-1:0]  shreg_r;
    logic [CW-1:0] bit_count_r;
    logic [N-1:0]  parallel_r;
    logic          overrun_r;

    logic [N-1:0]  word_s;
    logic          word_done_s;
    logic          load_s;
    logic          drop_s;

    // frame_clr suppresses completion, so the bit sampled on a clear edge is discarded.
    assign word_s      = {shreg_r[N-2:0], bus.serial_in};
    assign word_done_s = bus.shift_en && !bus.frame_clr && (bit_count_r == CW'(N - 1));

    // State register for the output holding FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: a completed word always leaves the register full; otherwise a ready drains it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (word_done_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (word_done_s) begin
                    state_next_s = ST_FULL;
                end else if (bus.out_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // FSM outputs: load the new word, or drop it when full and not being drained.
    always_comb begin
        load_s = 1'b0;
        drop_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                load_s = word_done_s;
                drop_s = 1'b0;
            end
            ST_FULL: begin
                if (word_done_s && bus.out_ready) begin
                    load_s = 1'b1;
                    drop_s = 1'b0;
                end else if (word_done_s) begin
                    load_s = 1'b0;
                    drop_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                    drop_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
                drop_s = 1'b0;
            end
        endcase
    end

    // Shift register and bit counter; clear wins over shifting, and the counter wraps on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r     <= {N{1'b0}};
            bit_count_r <= {CW{1'b0}};
        end else if (bus.frame_clr) begin
            shreg_r     <= {N{1'b0}};
            bit_count_r <= {CW{1'b0}};
        end else if (bus.shift_en) begin
            shreg_r     <= word_s;
            bit_count_r <= word_done_s ? {CW{1'b0}} : (bit_count_r + CW'(1));
        end else begin
            shreg_r     <= shreg_r;
            bit_count_r <= bit_count_r;
        end
    end

    // Holding register and sticky overrun flag; overrun is cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            parallel_r <= {N{1'b0}};
            overrun_r  <= 1'b0;
        end else begin
            if (load_s) begin
                parallel_r <= word_s;
            end else begin
                parallel_r <= parallel_r;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign bus.parallel_out = parallel_r;
    assign bus.out_valid    = (state_r == ST_FULL);
    assign bus.bit_count    = bit_count_r;
    assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer with N=4.
module tb_sipo_deserializer;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    sipo_deserializer_if #(.N(4)) bus ();

    sipo_deserializer #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: inputs applied now, outputs settled 1 time unit after the edge.
    task automatic cyc(input logic se, input logic si, input logic fc, input logic rdy, input logic rst);
        bus.shift_en  = se;
        bus.serial_in = si;
        bus.frame_clr = fc;
        bus.out_ready = rdy;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b, input logic rdy);
        cyc(1'b1, b, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic shift_word(input logic [3:0] w, input logic rdy);
        for (int i = 3; i >= 0; i--) begin
            shift_bit(w[i], rdy);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] par, input logic vld,
                             input logic [1:0] cnt, input logic ovr);
        check_eq({tag, ".par"}, 32'(bus.parallel_out), 32'(par));
        check_eq({tag, ".vld"}, 32'(bus.out_valid), 32'(vld));
        check_eq({tag, ".cnt"}, 32'(bus.bit_count), 32'(cnt));
        check_eq({tag, ".ovr"}, 32'(bus.overrun), 32'(ovr));
    endtask

    initial begin
        logic [3:0] gap_bits;
        n_total = 0;
        n_pass  = 0;
        bus.shift_en  = 1'b0;
        bus.serial_in = 1'b0;
        bus.frame_clr = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        #2;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Basic word, drained immediately
        shift_bit(1'b1, 1'b1);
        shift_bit(1'b0, 1'b1);
        check_eq("basic.cnt2", 32'(bus.bit_count), 32'd2);
        check_eq("basic.vld_mid", 32'(bus.out_valid), 32'd0);
        shift_bit(1'b1, 1'b1);
        shift_bit(1'b1, 1'b1);
        check_all("basic", 4'b1011, 1'b1, 2'd0, 1'b0);
        idle(1'b1);
        check_eq("basic.drain_vld", 32'(bus.out_valid), 32'd0);
        check_eq("basic.drain_par", 32'(bus.parallel_out), 32'hb);

        // Gaps of two idle cycles between bits
        gap_bits = 4'b0110;
        for (int i = 3; i >= 0; i--) begin
            shift_bit(gap_bits[i], 1'b1);
            if (i != 0) begin
                idle(1'b1);
                idle(1'b1);
                check_eq("gap.cnt_hold", 32'(bus.bit_count), 32'(4 - i));
            end
        end
        check_all("gap", 4'b0110, 1'b1, 2'd0, 1'b0);
        idle(1'b1);
        check_eq("gap.drain_vld", 32'(bus.out_valid), 32'd0);

        // Backpressure: second word dropped, overrun sticks
        shift_word(4'b1011, 1'b0);
        check_all("bp.first", 4'b1011, 1'b1, 2'd0, 1'b0);
        shift_word(4'b0110, 1'b0);
        check_all("bp.drop", 4'b1011, 1'b1, 2'd0, 1'b1);
        idle(1'b1);
        check_all("bp.drain", 4'b1011, 1'b0, 2'd0, 1'b1);
        idle(1'b0);
        check_eq("bp.ovr_sticky", 32'(bus.overrun), 32'd1);

        // Reset clears sticky overrun before the simultaneous case
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_all("rst2", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Simultaneous drain and completion
        shift_word(4'b1011, 1'b0);
        shift_bit(1'b0, 1'b0);
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b0, 1'b0);
        check_eq("sim.hold_par", 32'(bus.parallel_out), 32'hb);
        check_eq("sim.cnt3", 32'(bus.bit_count), 32'd3);
        shift_bit(1'b1, 1'b1);
        check_all("sim", 4'b0101, 1'b1, 2'd0, 1'b0);
        idle(1'b1);

        // Frame clear discards partial word and the bit sampled with it
        shift_bit(1'b1, 1'b1);
        shift_bit(1'b1, 1'b1);
        check_eq("clr.cnt2", 32'(bus.bit_count), 32'd2);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_all("clr", 4'b0101, 1'b0, 2'd0, 1'b0);
        shift_word(4'b0110, 1'b0);
        check_all("clr.word", 4'b0110, 1'b1, 2'd0, 1'b0);

        // Frame clear on the would-be completing edge: no completion, FULL untouched
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_all("clr.last", 4'b0110, 1'b1, 2'd0, 1'b0);

        // Reset mid-operation while full, overriding all other inputs
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b0, 1'b0);
        shift_bit(1'b1, 1'b0);
        check_eq("rstmid.cnt3", 32'(bus.bit_count), 32'd3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_all("rstmid", 4'b0000, 1'b0, 2'd0, 1'b0);
        shift_bit(1'b1, 1'b0);
        check_eq("rstmid.cnt1", 32'(bus.bit_count), 32'd1);
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b0, 1'b0);
        shift_bit(1'b0, 1'b0);
        check_all("rstmid.word", 4'b1100, 1'b1, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter N, default 4: word width in bits, N >= 2.
REQ-002 Parameter CW, default $clog2(N): width of bit_count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 shift_en  input  1  when high, serial_in is sampled this edge.
REQ-006 serial_in  input  1  serial data bit, MSB of each word first.
REQ-007 frame_clr  input  1  discard partially received word.
REQ-008 out_ready  input  1  downstream accepts parallel_out this edge.
REQ-009 parallel_out  output  N  last completed word, registered.
REQ-010 out_valid  output  1  parallel_out holds an unconsumed word.
REQ-011 bit_count  output  CW  bits received in current word, 0..N-1.
REQ-012 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 Internal shift register shreg[N-1:0]; on shift_en edge: shreg <= {shreg[N-2:0], serial_in}; bit_count increments by 1.
REQ-014 When shift_en is high and bit_count == N-1, the edge completes a word W = {shreg[N-2:0], serial_in}; bit_count wraps to 0; first received bit lands in W[N-1].
REQ-015 Latency: W appears on parallel_out and out_valid rises on the same edge that samples the Nth bit (visible immediately after that edge).
REQ-016 shift_en low: shreg and bit_count hold; gaps of any length between bits are legal.
REQ-017 Output FSM, two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-018 EMPTY + word complete -> FULL, parallel_out <= W; out_ready ignored in EMPTY.
REQ-019 FULL + out_ready high, no completion -> EMPTY; parallel_out holds its value.
REQ-020 FULL + out_ready high + completion on same edge -> stay FULL, parallel_out <= W, overrun unchanged.
REQ-021 FULL + out_ready low + completion -> stay FULL, W dropped, parallel_out unchanged, overrun <= 1.
REQ-022 parallel_out changes only per REQ-018/REQ-020; stable while FULL otherwise.
REQ-023 frame_clr high: shreg <= 0, bit_count <= 0; overrides shift_en on same edge (bit discarded, no completion); out_valid, parallel_out, overrun unaffected.
REQ-024 overrun clears only on reset.

Reset
REQ-025 reset high at an edge: shreg, bit_count, parallel_out, out_valid, overrun all <= 0; FSM -> EMPTY.
REQ-026 reset overrides frame_clr, shift_en and out_ready; mid-word bits and any held word are discarded.
REQ-027 First bit sampled after reset deasserts starts a new word at bit_count 0.

Verification (N=4)
REQ-028 Basic: after reset, out_ready=1, shift 1,0,1,1 on 4 consecutive edges -> after 4th edge parallel_out=4'b1011, out_valid=1 for one cycle, bit_count=0, overrun=0.
REQ-029 Gaps: bits 0,1,1,0 with 2 idle cycles between each -> bit_count holds in gaps; parallel_out=4'b0110 after last bit.
REQ-030 Backpressure: out_ready=0, send 1011 then 0110 -> parallel_out stays 4'b1011, out_valid=1, overrun=1; raise out_ready one cycle -> out_valid=0, overrun stays 1.
REQ-031 Simultaneous: FULL holding 1011, out_ready=1 on edge sampling 4th bit of 0101 -> parallel_out=4'b0101, out_valid=1, overrun=0.
REQ-032 Clear: shift 1,1, assert frame_clr with shift_en=1, serial_in=1 -> bit_count=0; then shift 0,1,1,0 -> parallel_out=4'b0110.
REQ-033 Reset mid-operation: FULL with 3 bits of next word received, assert reset -> all outputs 0 next edge; then 1,1,0,0 -> parallel_out=4'b1100.
